presc_updown_counter: RTL

Parametrised up/down counter with a built-in clock-enable prescaler, wrap/saturate mode, a programmable upper limit, and a terminal-count flag. It is the general-purpose successor of the fixed 4-bit prescaled lab counter. It drives LED/7-segment displays and slow timing in board designs, and serves as a tick source for other blocks.

---
 rtl/presc_updown_counter.sv | 75 +++++++
 1 files changed

// File: rtl/presc_updown_counter.sv
// Up/down counter stepped by an internal clock-enable prescaler, with wrap or
// saturate at a programmable upper limit and a one-cycle terminal-count pulse.
module presc_updown_counter #(
  parameter int WIDTH = 8,
  parameter int DIV   = 25_000_000,
  parameter int LIMIT = 2**WIDTH - 1,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             tc
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0]    PMAX  = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] LIM   = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(INIT);

  logic [PW-1:0] pcnt;

  // The step is gated by the registered tick, so q moves on the edge that
  // closes the cycle in which tick is visible.
  // NOTE: every register here uses non-blocking assignment so all of them
  // sample the same pre-edge values; blocking would make q see the new tick.
  always_ff @(posedge clk) begin
    if (sclr) begin
      q    <= RST_Q;
      pcnt <= '0;
      tick <= 1'b0;
      tc   <= 1'b0;
    end else begin
      // Free-running prescaler: clr and load never disturb its phase.
      if (pcnt == PMAX) begin
        pcnt <= '0;
        tick <= 1'b1;
      end else begin
        pcnt <= pcnt + 1'b1;
        tick <= 1'b0;
      end

      tc <= 1'b0;
      if (clr) begin
        q <= '0;
      end else if (load) begin
        q <= (din > LIM) ? LIM : din;
      end else if (tick && en) begin
        if (dir) begin
          if (q == LIM) begin
            tc <= 1'b1;
            if (!mode) q <= '0;
          end else begin
            q <= q + 1'b1;
          end
        end else begin
          if (q == '0) begin
            tc <= 1'b1;
            if (!mode) q <= LIM;
          end else begin
            q <= q - 1'b1;
          end
        end
      end
    end
  end

endmodule
